// File: rtl/apb_irq_ctrl.sv
// rtl/apb_irq_ctrl.sv - APB interrupt controller: pending latch, mask, priority arbitration, valid/ready presentation
module apb_irq_ctrl #(
    parameter int NrSrc     = 16,
    parameter int PrioWidth = 3,
    parameter int AddrWidth = 32,
    localparam int IdWidth  = (NrSrc > 1) ? $clog2(NrSrc) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    input  logic [NrSrc-1:0]     irq_src_i,
    output logic                 irq_valid_o,
    output logic [IdWidth-1:0]   irq_id_o,
    output logic [PrioWidth-1:0] irq_prio_o,
    input  logic                 irq_ready_i
);

    typedef enum logic [1:0] {IDLE, PRESENT, ACK} state_e;

    state_e               state_q, state_d;
    logic [NrSrc-1:0]     pending_q, enable_q, trig_q, src_q;
    logic [PrioWidth-1:0] thresh_q;
    logic [PrioWidth-1:0] prio_q [NrSrc];
    logic [IdWidth-1:0]   id_q, id_d;
    logic [PrioWidth-1:0] pout_q, pout_d;

    logic                 access, wr, mapped, handshake;
    logic [7:0]           off;
    logic [31:0]          rdata;
    logic [NrSrc-1:0]     prio_hit, elig, set_v, w1c, hs_clr;
    logic                 any_elig, cur_elig;
    logic [IdWidth-1:0]   best_id;
    logic [PrioWidth-1:0] best_prio;
    logic                 unused_bits;

    assign access      = psel_i & penable_i;
    assign wr          = access & pwrite_i;
    assign off         = paddr_i[7:0];
    assign pready_o    = 1'b1;
    assign unused_bits = ^{paddr_i, pwdata_i};

    always_comb begin
        for (int i = 0; i < NrSrc; i++) begin
            prio_hit[i] = (off == 8'(64 + 4 * i));
        end
    end

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (off)
            8'h00:   rdata[NrSrc-1:0]     = pending_q;
            8'h04:   rdata[NrSrc-1:0]     = enable_q;
            8'h08:   rdata[NrSrc-1:0]     = trig_q;
            8'h0C:   rdata[PrioWidth-1:0] = thresh_q;
            default: begin
                mapped = |prio_hit;
                for (int i = 0; i < NrSrc; i++) begin
                    if (prio_hit[i]) rdata[PrioWidth-1:0] = prio_q[i];
                end
            end
        endcase
    end

    assign prdata_o  = access ? rdata : '0;
    assign pslverr_o = access & ~mapped;

    // Strict '>' while scanning upward keeps the lowest index on priority ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        any_elig  = 1'b0;
        cur_elig  = 1'b0;
        for (int i = 0; i < NrSrc; i++) begin
            elig[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
        end
        for (int i = 0; i < NrSrc; i++) begin
            if (elig[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = IdWidth'(i);
                any_elig  = 1'b1;
            end
            if (id_q == IdWidth'(i)) cur_elig = elig[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        pout_d    = pout_q;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = PRESENT;
                    id_d    = best_id;
                    pout_d  = best_prio;
                end
            end
            PRESENT: begin
                // A completed handshake is honoured even if the source just lost eligibility.
                if (irq_ready_i) begin
                    handshake = 1'b1;
                    state_d   = ACK;
                end else if (!cur_elig) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign irq_valid_o = (state_q == PRESENT);
    assign irq_id_o    = id_q;
    assign irq_prio_o  = pout_q;

    always_comb begin
        set_v = (trig_q & irq_src_i & ~src_q) | (~trig_q & irq_src_i);
        w1c   = (wr && (off == 8'h00)) ? pwdata_i[NrSrc-1:0] : '0;
        for (int i = 0; i < NrSrc; i++) begin
            hs_clr[i] = handshake && (id_q == IdWidth'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            id_q      <= '0;
            pout_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            trig_q    <= '0;
            src_q     <= '0;
            thresh_q  <= '0;
            for (int i = 0; i < NrSrc; i++) prio_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pout_q    <= pout_d;
            src_q     <= irq_src_i;
            pending_q <= (pending_q & ~(w1c | hs_clr)) | set_v;
            if (wr && (off == 8'h04)) enable_q <= pwdata_i[NrSrc-1:0];
            if (wr && (off == 8'h08)) trig_q   <= pwdata_i[NrSrc-1:0];
            if (wr && (off == 8'h0C)) thresh_q <= pwdata_i[PrioWidth-1:0];
            for (int i = 0; i < NrSrc; i++) begin
                if (wr && prio_hit[i]) prio_q[i] <= pwdata_i[PrioWidth-1:0];
            end
        end
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// tb/tb_apb_irq_ctrl.sv - self-checking bench for apb_irq_ctrl with a behavioural model
module tb_apb_irq_ctrl;

    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] src = '0;
    logic        valid;
    logic [3:0]  id;
    logic [2:0]  prio;
    logic        ready = 1'b0;

    int checks = 0;
    int failures = 0;

    apb_irq_ctrl #(.NrSrc(16), .PrioWidth(3), .AddrWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .irq_src_i(src), .irq_valid_o(valid), .irq_id_o(id),
        .irq_prio_o(prio), .irq_ready_i(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [15:0] m_pend, m_en, m_trig, m_srcq;
    int          m_thr;
    int          m_prio [NS];
    bit          m_valid, m_bubble;
    int          m_id, m_pr;

    function automatic bit m_elig(int i);
        return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
    endfunction

    function automatic bit m_prio_addr(int off);
        return off >= 64 && off % 4 == 0 && (off - 64) / 4 < NS;
    endfunction

    task automatic m_read(input int off, output logic [31:0] d, output logic err);
        d = 0;
        err = 0;
        if (off == 0) d = 32'(m_pend);
        else if (off == 4) d = 32'(m_en);
        else if (off == 8) d = 32'(m_trig);
        else if (off == 12) d = 32'(m_thr);
        else if (m_prio_addr(off)) d = 32'(m_prio[(off - 64) / 4]);
        else err = 1;
    endtask

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_trig = 0; m_srcq = 0; m_thr = 0;
        for (int i = 0; i < NS; i++) m_prio[i] = 0;
        m_valid = 0; m_bubble = 0; m_id = 0; m_pr = 0;
    endtask

    task automatic model_step();
        bit          hs;
        int          old_id, win, wp, off;
        logic [15:0] set_v, clr;
        hs = m_valid && ready;
        old_id = m_id;
        if (m_valid) begin
            if (hs) begin
                m_valid = 0;
                m_bubble = 1;
            end else if (!m_elig(m_id)) begin
                m_valid = 0;
            end
        end else if (m_bubble) begin
            m_bubble = 0;
        end else begin
            win = -1;
            wp = 0;
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_elig(i) && m_prio[i] >= wp) begin
                    win = i;
                    wp = m_prio[i];
                end
            end
            if (win >= 0) begin
                m_valid = 1;
                m_id = win;
                m_pr = wp;
            end
        end
        set_v = (m_trig & src & ~m_srcq) | (~m_trig & src);
        clr = 0;
        if (hs) clr[old_id] = 1'b1;
        if (psel && penable && pwrite) begin
            off = int'(paddr[7:0]);
            if (off == 0) clr = clr | pwdata[15:0];
            else if (off == 4) m_en = pwdata[15:0];
            else if (off == 8) m_trig = pwdata[15:0];
            else if (off == 12) m_thr = int'(pwdata[2:0]);
            else if (m_prio_addr(off)) m_prio[(off - 64) / 4] = int'(pwdata[2:0]);
        end
        m_pend = (m_pend & ~clr) | set_v;
        m_srcq = src;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        if (rst_n) model_step();
    endtask

    task automatic apb_write(input int a, input logic [31:0] d);
        tick();
        psel = 1; penable = 0; pwrite = 1; paddr = 32'(a); pwdata = d;
        tick();
        penable = 1;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input int a, output logic [31:0] d, output logic e,
                            output logic [31:0] ed, output logic ee);
        tick();
        psel = 1; penable = 0; pwrite = 0; paddr = 32'(a);
        tick();
        penable = 1;
        #1;
        d = prdata;
        e = pslverr;
        m_read(a, ed, ee);
        tick();
        psel = 0; penable = 0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 0;
        for (int k = 0; k < max; k++) begin
            tick();
            if (valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_src(input logic [15:0] bits);
        tick();
        src = bits;
        tick();
        src = '0;
    endtask

    task automatic handshake();
        tick();
        ready = 1;
        tick();
        ready = 0;
    endtask

    task automatic quiesce();
        src = '0;
        ready = 0;
        apb_write(4, 0);
        apb_write(0, 32'hFFFF);
        repeat (3) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        logic [31:0] d, ed;
        logic e, ee;
        int regs [5] = '{0, 4, 8, 12, 64};
        apb_write(8, 1);
        apb_write(4, 1);
        apb_write(64, 2);
        pulse_src(16'h0001);
        wait_valid(6, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_setup_valid: got 0 expected 1"); end
        tick();
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (valid !== 1'b0 || id !== 4'd0 || prio !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b id=%0d prio=%0d expected 0 0 0", valid, id, prio);
        end
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0 || prdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_apb_outputs: got pready=%0b pslverr=%0b prdata=%0h expected 1 0 0", pready, pslverr, prdata);
        end
        tick();
        rst_n = 1;
        foreach (regs[k]) begin
            apb_read(regs[k], d, e, ed, ee);
            checks++;
            if (d !== 32'd0 || e !== 1'b0) begin
                failures++;
                $display("FAIL reset_reg_%0h: got %0h err=%0b expected 0 err=0", regs[k], d, e);
            end
        end
        apb_read(32'h20, d, e, ed, ee);
        checks++;
        if (d !== 32'd0 || e !== 1'b1) begin
            failures++;
            $display("FAIL unmapped_0x20: got data=%0h err=%0b expected 0 err=1", d, e);
        end
    endtask

    task automatic test_setup();
        bit ok;
        logic [31:0] d, ed;
        logic e, ee;
        quiesce();
        apb_write(8, 32'h80);
        apb_write(4, 32'h80);
        apb_write(64 + 4 * 7, 3);
        apb_write(12, 0);
        pulse_src(16'h0080);
        wait_valid(4, ok);
        checks++;
        if (!ok || id !== 4'd7 || prio !== 3'd3) begin
            failures++;
            $display("FAIL setup_present: got valid=%0b id=%0d prio=%0d expected 1 7 3", valid, id, prio);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || id !== 4'd7 || prio !== 3'd3) begin
                failures++;
                $display("FAIL setup_hold_%0d: got valid=%0b id=%0d prio=%0d expected 1 7 3", k, valid, id, prio);
            end
        end
        handshake();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL setup_bubble_%0d: got valid=%0b expected 0", k, valid);
            end
            tick();
        end
        apb_read(0, d, e, ed, ee);
        checks++;
        if (d !== 32'h0000 || d !== ed) begin
            failures++;
            $display("FAIL setup_pending_cleared: got %0h expected 0", d);
        end
    endtask

    task automatic test_priority();
        bit ok;
        int exp_id [3] = '{4, 2, 9};
        int exp_pr [3] = '{6, 5, 5};
        quiesce();
        apb_write(8, 32'hFFFF);
        apb_write(4, 32'h0214);
        apb_write(64 + 4 * 2, 5);
        apb_write(64 + 4 * 9, 5);
        apb_write(64 + 4 * 4, 6);
        apb_write(12, 0);
        pulse_src(16'h0214);
        for (int k = 0; k < 3; k++) begin
            wait_valid(6, ok);
            checks++;
            if (!ok || int'(id) != exp_id[k] || int'(prio) != exp_pr[k]) begin
                failures++;
                $display("FAIL priority_order_%0d: got valid=%0b id=%0d prio=%0d expected 1 %0d %0d",
                         k, valid, id, prio, exp_id[k], exp_pr[k]);
            end
            handshake();
        end
    endtask

    task automatic test_threshold();
        bit ok;
        logic [31:0] d, ed;
        logic e, ee;
        quiesce();
        apb_write(8, 32'h8);
        apb_write(4, 32'h8);
        apb_write(12, 5);
        apb_write(64 + 4 * 3, 5);
        pulse_src(16'h0008);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL thresh_equal_blocks_%0d: got valid=%0b expected 0", k, valid);
            end
        end
        apb_write(12, 4);
        wait_valid(5, ok);
        checks++;
        if (!ok || id !== 4'd3) begin
            failures++;
            $display("FAIL thresh_lowered: got valid=%0b id=%0d expected 1 3", valid, id);
        end
        apb_write(12, 7);
        ok = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL thresh_retract: got valid=1 expected 0"); end
        apb_read(0, d, e, ed, ee);
        checks++;
        if (d[3] !== 1'b1 || d !== ed) begin
            failures++;
            $display("FAIL thresh_pending_kept: got %0h expected %0h", d, ed);
        end
    endtask

    task automatic test_level();
        bit ok;
        logic [31:0] d, ed;
        logic e, ee;
        quiesce();
        apb_write(8, 0);
        apb_write(4, 32'h2);
        apb_write(64 + 4 * 1, 2);
        apb_write(12, 0);
        tick();
        src = 16'h0002;
        wait_valid(5, ok);
        checks++;
        if (!ok || id !== 4'd1) begin
            failures++;
            $display("FAIL level_present: got valid=%0b id=%0d expected 1 1", valid, id);
        end
        handshake();
        apb_read(0, d, e, ed, ee);
        checks++;
        if (d[1] !== 1'b1 || d !== ed) begin
            failures++;
            $display("FAIL level_repend: got %0h expected %0h", d, ed);
        end
        wait_valid(5, ok);
        checks++;
        if (!ok || id !== 4'd1) begin
            failures++;
            $display("FAIL level_reassert: got valid=%0b id=%0d expected 1 1", valid, id);
        end
        src = '0;
    endtask

    task automatic test_collision();
        bit ok;
        logic [31:0] d, ed;
        logic e, ee;
        quiesce();
        apb_write(8, 32'h20);
        apb_write(64 + 4 * 5, 4);
        apb_write(12, 0);
        pulse_src(16'h0020);
        tick();
        psel = 1; penable = 0; pwrite = 1; paddr = 0; pwdata = 32'h20;
        tick();
        penable = 1;
        src = 16'h0020;
        tick();
        psel = 0; penable = 0; pwrite = 0;
        apb_read(0, d, e, ed, ee);
        checks++;
        if (d[5] !== 1'b1 || d !== ed) begin
            failures++;
            $display("FAIL collision_w1c: got %0h expected %0h", d, ed);
        end
        src = '0;
        apb_write(4, 32'h20);
        wait_valid(5, ok);
        checks++;
        if (!ok || id !== 4'd5) begin
            failures++;
            $display("FAIL collision_present: got valid=%0b id=%0d expected 1 5", valid, id);
        end
        tick();
        ready = 1;
        src = 16'h0020;
        tick();
        ready = 0;
        src = '0;
        apb_read(0, d, e, ed, ee);
        checks++;
        if (d[5] !== 1'b1 || d !== ed) begin
            failures++;
            $display("FAIL collision_handshake: got %0h expected %0h", d, ed);
        end
    endtask

    task automatic test_random();
        int r, off;
        logic [31:0] ed;
        logic ee;
        quiesce();
        for (int c = 0; c < 1500; c++) begin
            tick();
            src = 16'($urandom & $urandom & $urandom);
            ready = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            psel = (r < 4);
            penable = (r < 3);
            pwrite = $urandom_range(0, 1);
            case ($urandom_range(0, 6))
                0: off = 0;
                1: off = 4;
                2: off = 8;
                3: off = 12;
                4, 5: off = 64 + 4 * $urandom_range(0, NS - 1);
                default: off = $urandom_range(0, 255);
            endcase
            paddr = ($urandom & 32'hFFFF_FF00) | 32'(off);
            pwdata = $urandom;
            #1;
            checks++;
            if (valid !== m_valid || (m_valid && (int'(id) != m_id || int'(prio) != m_pr))) begin
                failures++;
                $display("FAIL random_irq_c%0d: got valid=%0b id=%0d prio=%0d expected %0b %0d %0d",
                         c, valid, id, prio, m_valid, m_id, m_pr);
            end
            m_read(off, ed, ee);
            if (!(psel && penable)) begin
                ed = 0;
                ee = 0;
            end
            checks++;
            if (prdata !== ed || pslverr !== ee || pready !== 1'b1) begin
                failures++;
                $display("FAIL random_apb_c%0d: got data=%0h err=%0b expected %0h err=%0b",
                         c, prdata, pslverr, ed, ee);
            end
        end
        tick();
        psel = 0; penable = 0; pwrite = 0; ready = 0; src = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_setup();
        test_priority();
        test_threshold();
        test_level();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
